// File: rtl/vector_add_sequencer.sv
// Streams operand pairs A[i],B[i] to an external fixed-latency adder, one element per
// cycle, and collects the returned results into the result buffer R.
module vector_add_sequencer #(
   parameter int nBits = 32,
   parameter int N     = 4,
   parameter int LAT   = 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   wr_en,
   input  logic                   wr_sel,
   input  logic [$clog2(N)-1:0]   wr_addr,
   input  logic [nBits-1:0]       wr_data,
   input  logic                   start,
   input  logic                   op,
   output logic                   busy,
   output logic                   done,
   output logic [nBits-1:0]       add_a,
   output logic [nBits-1:0]       add_b,
   output logic                   add_sum,
   output logic                   add_en,
   input  logic [nBits-1:0]       add_res,
   input  logic [$clog2(N)-1:0]   rd_addr,
   output logic [nBits-1:0]       rd_data
);

   localparam int AW = $clog2(N);
   localparam logic [AW-1:0] LAST_IDX = AW'(N - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_DRAIN, ST_DONE} state_t;

   state_t           state_q;
   logic [nBits-1:0] a_mem [N];
   logic [nBits-1:0] b_mem [N];
   logic [nBits-1:0] r_mem [N];
   logic [AW-1:0]    i_q;
   logic             op_q;
   logic             busy_q;
   logic             done_q;
   logic             add_en_q;
   logic [nBits-1:0] add_a_q;
   logic [nBits-1:0] add_b_q;

   logic [AW-1:0]    nxt_idx_d;
   logic [nBits-1:0] a_nxt_d;
   logic [nBits-1:0] b_nxt_d;
   logic             tag_vld;
   logic [AW-1:0]    tag_idx;

   // Operand outputs are registered, so the next element is fetched one cycle early;
   // a write landing in the start cycle is forwarded so the run sees the new value.
   always_comb begin
      nxt_idx_d = (state_q == ST_ISSUE) ? i_q + 1'b1 : '0;
      a_nxt_d   = a_mem[nxt_idx_d];
      b_nxt_d   = b_mem[nxt_idx_d];
      if (state_q == ST_IDLE && wr_en && wr_addr == nxt_idx_d) begin
         if (wr_sel) b_nxt_d = wr_data;
         else        a_nxt_d = wr_data;
      end
   end

   generate
      if (LAT == 0) begin : g_nolat
         assign tag_vld = add_en_q;
         assign tag_idx = i_q;
      end else begin : g_lat
         logic [LAT-1:0]         vld_q;
         logic [LAT-1:0][AW-1:0] idx_q;
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               vld_q <= '0;
               idx_q <= '0;
            end else begin
               vld_q[0] <= add_en_q;
               idx_q[0] <= i_q;
               for (int s = 1; s < LAT; s++) begin
                  vld_q[s] <= vld_q[s-1];
                  idx_q[s] <= idx_q[s-1];
               end
            end
         end
         assign tag_vld = vld_q[LAT-1];
         assign tag_idx = idx_q[LAT-1];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         i_q      <= '0;
         op_q     <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         add_en_q <= 1'b0;
         add_a_q  <= '0;
         add_b_q  <= '0;
         for (int k = 0; k < N; k++) begin
            a_mem[k] <= '0;
            b_mem[k] <= '0;
            r_mem[k] <= '0;
         end
      end else begin
         if (state_q == ST_IDLE && wr_en) begin
            if (wr_sel) b_mem[wr_addr] <= wr_data;
            else        a_mem[wr_addr] <= wr_data;
         end
         if (tag_vld) r_mem[tag_idx] <= add_res;
         done_q   <= 1'b0;
         add_en_q <= 1'b0;
         case (state_q)
            ST_IDLE, ST_DONE: begin
               state_q <= ST_IDLE;
               if (start) begin
                  state_q  <= ST_ISSUE;
                  op_q     <= op;
                  i_q      <= '0;
                  busy_q   <= 1'b1;
                  add_en_q <= 1'b1;
                  add_a_q  <= a_nxt_d;
                  add_b_q  <= b_nxt_d;
               end
            end
            ST_ISSUE: begin
               if (i_q == LAST_IDX) begin
                  if (LAT == 0) begin
                     state_q <= ST_DONE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= ST_DRAIN;
                  end
               end else begin
                  i_q      <= nxt_idx_d;
                  add_en_q <= 1'b1;
                  add_a_q  <= a_nxt_d;
                  add_b_q  <= b_nxt_d;
               end
            end
            ST_DRAIN: begin
               if (tag_vld && tag_idx == LAST_IDX) begin
                  state_q <= ST_DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign add_en  = add_en_q;
   assign add_a   = add_a_q;
   assign add_b   = add_b_q;
   assign add_sum = op_q;
   assign rd_data = r_mem[rd_addr];

endmodule

// File: doc/vector_add_sequencer.md
VECTOR_ADD_SEQUENCER -- requirements
Module: vector_add_sequencer

Interface
REQ-001 The block SHALL have parameter nBits, default 32, meaning operand/result word width (IEEE-754 single for RLS use).
REQ-002 The block SHALL have parameter N, default 4, meaning vector length (2..16).
REQ-003 The block SHALL have parameter LAT, default 1, meaning adder latency in cycles from operand presentation to valid add_res (0..15).
REQ-004 The block SHALL have port clk, input, 1, the only clock; all logic on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1, with reset synchronous and active-low.
REQ-006 The block SHALL have port wr_en, input, 1, operand write strobe.
REQ-007 The block SHALL have port wr_sel, input, 1, operand bank select: 0=A, 1=B.
REQ-008 The block SHALL have port wr_addr, input, clog2(N), operand element index.
REQ-009 The block SHALL have port wr_data, input, nBits, operand write data.
REQ-010 The block SHALL have port start, input, 1, request to process the whole vector.
REQ-011 The block SHALL have port op, input, 1, sampled with start: 1=add (A+B), 0=subtract (A-B).
REQ-012 The block SHALL have port busy, output, 1, operation in progress.
REQ-013 The block SHALL have port done, output, 1, one-cycle completion pulse.
REQ-014 The block SHALL have ports add_a and add_b, output, nBits each, operands to the downstream adder.
REQ-015 The block SHALL have port add_sum, output, 1, add/subtract select to the adder.
REQ-016 The block SHALL have port add_en, output, 1, adder enable, high only while an element is issued.
REQ-017 The block SHALL have port add_res, input, nBits, adder result.
REQ-018 The block SHALL have port rd_addr, input, clog2(N), result element index.
REQ-019 The block SHALL have port rd_data, output, nBits, combinational read of result buffer R[rd_addr].

Function
REQ-020 The FSM SHALL have states IDLE, ISSUE, DRAIN and DONE.
REQ-021 In IDLE, a write with wr_en=1 SHALL store wr_data into A[wr_addr] or B[wr_addr] per wr_sel; wr_en SHALL be ignored in all other states.
REQ-022 In IDLE or DONE, start=1 SHALL latch op and move to ISSUE; start SHALL be ignored in ISSUE and DRAIN.
REQ-023 When wr_en and start occur in the same IDLE cycle, the write SHALL complete and the operation SHALL use the newly written value.
REQ-024 In ISSUE, an index counter i SHALL run 0..N-1, one element per cycle, driving add_a=A[i], add_b=B[i], add_sum=latched op and add_en=1.
REQ-025 Outside ISSUE, add_en SHALL be 0 and add_a/add_b SHALL be held at their last values.
REQ-026 A valid/index tag SHALL be delayed by LAT cycles; add_res SHALL be written to R[tag index] at the end of the cycle in which the tag emerges (with LAT=0, the issue cycle itself).
REQ-027 After issuing i=N-1, the FSM SHALL go to DRAIN, or directly to DONE when LAT=0.
REQ-028 The FSM SHALL stay in DRAIN until the last tag is captured, then go to DONE.
REQ-029 With start sampled at edge E0, element k SHALL be issued in cycle k+1, and done SHALL be high in cycle N+LAT+1 only.
REQ-030 busy SHALL be 1 in ISSUE and DRAIN, and 0 in IDLE and DONE.
REQ-031 DONE SHALL last one cycle, then go to IDLE, or to ISSUE if start=1 (back-to-back operation, no gap).
REQ-032 R elements SHALL update as they are captured; rd_data during busy SHALL be permitted to mix old and new results.
REQ-033 No arithmetic SHALL be performed in this block; the operand and result width SHALL be nBits throughout with no truncation.

Reset
REQ-034 rst_n=0 at a clock edge SHALL force IDLE, clear i and all delay tags, and zero A, B, R and the latched op.
REQ-035 rst_n=0 SHALL drive busy=0, done=0, add_en=0, add_a=0, add_b=0 and add_sum=0.
REQ-036 Reset asserted mid-operation SHALL abort immediately, capture no further results, and not pulse done.

Verification
REQ-037 The bench SHALL use a behavioural adder model with LAT.
REQ-038 Scenario (LAT=1): A={3F800000,40000000,40400000,40800000}, B=4x3F800000, start op=1 -> add_en high in cycles 1-4; R={40000000,40400000,40800000,40A00000}; done in cycle 6 only.
REQ-039 Scenario: same operands, op=0 -> add_sum=0 throughout; R={00000000,3F800000,40000000,40400000}.
REQ-040 Scenario (LAT=0 build): operation completes with done in cycle N+1=5; results as in REQ-038.
REQ-041 Scenario: start re-asserted in the DONE cycle -> the next operation issues element 0 in the following cycle; start pulses during busy have no effect.
REQ-042 Scenario: wr_en during busy to A[0]=0x41200000 -> A is unchanged; the next run still yields R[0]=40000000.
REQ-043 Scenario: rst_n=0 in cycle 3 of a run -> busy=0 and add_en=0 next cycle; no done pulse; rd_data=0 for all indices.
